// File: rtl/fetch_ctrl_pkg.sv
// Shared types and bram select encodings for the fetch load sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_WAIT_PE
    } state_t;

    typedef enum logic [1:0] {
        PH_IN,
        PH_KER,
        PH_INS
    } phase_t;

    localparam logic [1:0] BRAM_SEL_INPUT  = 2'b00;
    localparam logic [1:0] BRAM_SEL_KERNEL = 2'b01;
    localparam logic [1:0] BRAM_SEL_INSTR  = 2'b10;
    localparam logic [1:0] BRAM_SEL_NONE   = 2'b11;

    function automatic logic [1:0] sel_of(input phase_t p);
        unique case (p)
            PH_IN:   return BRAM_SEL_INPUT;
            PH_KER:  return BRAM_SEL_KERNEL;
            default: return BRAM_SEL_INSTR;
        endcase
    endfunction

endpackage

// File: rtl/load_beat_counter.sv
// Beat counter for one load phase; flags the beat that reaches len.
module load_beat_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             last
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)      count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + ONE;
    end

    assign last = (count == len - ONE);

endmodule

// File: rtl/fetch_load_sequencer.sv
// Sequences input/kernel/instr loads into the fetch unit, then runs the PE array.
// Optional idle-beat watchdog enabled by defining LOAD_TIMEOUT_EN.
module fetch_load_sequencer
    import fetch_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
`ifdef LOAD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             S_AXIS_ACLK,
    input  logic             S_AXIS_ARESET,
    input  logic             start,
    input  logic [31:0]      cfg_row_width,
    input  logic [LEN_W-1:0] cfg_input_len,
    input  logic [LEN_W-1:0] cfg_kernel_len,
    input  logic [LEN_W-1:0] cfg_instr_len,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             fu_tvalid,
    output logic             fu_tlast,
    output logic [1:0]       fu_bram_sel,
    output logic [31:0]      fu_row_width,
    output logic             pe_start,
    input  logic             pe_done,
    output logic             busy,
    output logic             done,
`ifdef LOAD_TIMEOUT_EN
    output logic             err_timeout,
`endif
    output logic             err_len,
    output logic             err_cfg
);

    state_t state, state_n;
    phase_t phase, phase_n, first_phase;

    logic [LEN_W-1:0] in_len, ker_len, ins_len, cur_len;
    logic accept, beat, term, cnt_last, timeout;

    assign accept = (state == ST_IDLE) && start;
    assign beat   = s_tvalid && s_tready;
    assign term   = beat && (s_tlast || cnt_last);

    assign first_phase = (cfg_input_len != '0)  ? PH_IN  :
                         (cfg_kernel_len != '0) ? PH_KER : PH_INS;

    always_comb begin
        cur_len = ins_len;
        unique case (phase)
            PH_IN:   cur_len = in_len;
            PH_KER:  cur_len = ker_len;
            default: cur_len = ins_len;
        endcase
    end

    load_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk (S_AXIS_ACLK),
        .rst (S_AXIS_ARESET),
        .clr (accept || term),
        .inc (beat),
        .len (cur_len),
        .last(cnt_last)
    );

`ifdef LOAD_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle_cnt;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET || state != ST_LOAD || beat)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + IW'(1);
    end

    assign timeout = (state == ST_LOAD) && !beat &&
                     (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET)  err_timeout <= 1'b0;
        else if (accept)    err_timeout <= 1'b0;
        else if (timeout)   err_timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State and phase register
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state <= ST_IDLE;
            phase <= PH_IN;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        unique case (state)
            ST_IDLE: begin
                if (accept && cfg_instr_len != '0) begin
                    state_n = ST_LOAD;
                    phase_n = first_phase;
                end
            end
            ST_LOAD: begin
                if (timeout)   state_n = ST_IDLE;
                else if (term) state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                unique case (phase)
                    PH_IN: begin
                        state_n = ST_LOAD;
                        phase_n = (ker_len != '0) ? PH_KER : PH_INS;
                    end
                    PH_KER: begin
                        state_n = ST_LOAD;
                        phase_n = PH_INS;
                    end
                    default: state_n = ST_RUN;
                endcase
            end
            ST_RUN:     state_n = ST_WAIT_PE;
            ST_WAIT_PE: if (pe_done) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        s_tready  = (state == ST_LOAD);
        fu_tvalid = s_tready && s_tvalid;
        // Forced on the count-terminated beat so the fetch pointer wraps.
        fu_tlast  = s_tready && (s_tlast || (s_tvalid && cnt_last));
        pe_start  = (state == ST_RUN);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            in_len       <= '0;
            ker_len      <= '0;
            ins_len      <= '0;
            fu_bram_sel  <= BRAM_SEL_NONE;
            fu_row_width <= '0;
            err_len      <= 1'b0;
            err_cfg      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == ST_WAIT_PE) && pe_done;
            if (accept) begin
                in_len  <= cfg_input_len;
                ker_len <= cfg_kernel_len;
                ins_len <= cfg_instr_len;
                err_len <= 1'b0;
                err_cfg <= (cfg_instr_len == '0);
            end
            if (state == ST_IDLE && state_n == ST_LOAD) begin
                fu_bram_sel  <= sel_of(phase_n);
                fu_row_width <= cfg_row_width;
            end
            if (state == ST_SETTLE)
                fu_bram_sel <= (state_n == ST_RUN) ? BRAM_SEL_NONE : sel_of(phase_n);
            if (timeout)
                fu_bram_sel <= BRAM_SEL_NONE;
            if (term && (s_tlast != cnt_last))
                err_len <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_load_sequencer.sv
// Directed self-checking bench for fetch_load_sequencer.
// Define LOAD_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_fetch_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_row_width;
    logic [15:0] cfg_input_len, cfg_kernel_len, cfg_instr_len;
    logic        s_tvalid, s_tlast, s_tready;
    logic        fu_tvalid, fu_tlast;
    logic [1:0]  fu_bram_sel;
    logic [31:0] fu_row_width;
    logic        pe_start, pe_done, busy, done, err_len, err_cfg;
`ifdef LOAD_TIMEOUT_EN
    logic        err_timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_load_sequencer #(
        .LEN_W(16)
`ifdef LOAD_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .start         (start),
        .cfg_row_width (cfg_row_width),
        .cfg_input_len (cfg_input_len),
        .cfg_kernel_len(cfg_kernel_len),
        .cfg_instr_len (cfg_instr_len),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .fu_tvalid     (fu_tvalid),
        .fu_tlast      (fu_tlast),
        .fu_bram_sel   (fu_bram_sel),
        .fu_row_width  (fu_row_width),
        .pe_start      (pe_start),
        .pe_done       (pe_done),
        .busy          (busy),
        .done          (done),
`ifdef LOAD_TIMEOUT_EN
        .err_timeout   (err_timeout),
`endif
        .err_len       (err_len),
        .err_cfg       (err_cfg)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int in_l, input int ker_l, input int ins_l,
                           input logic [31:0] rw);
        cfg_input_len  = 16'(in_l);
        cfg_kernel_len = 16'(ker_l);
        cfg_instr_len  = 16'(ins_l);
        cfg_row_width  = rw;
    endtask

    // Drives n back-to-back beats, s_tlast on beat tl (0 = never).
    task automatic beats(input int n, input int tl, output logic ftl, output logic ok);
        ok  = 1'b1;
        ftl = 1'b0;
        for (int i = 1; i <= n; i++) begin
            s_tvalid = 1'b1;
            s_tlast  = (i == tl);
            #1;
            if (!(s_tready && fu_tvalid)) ok = 1'b0;
            ftl = fu_tlast;
            cyc();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Entered at the SETTLE cycle that follows the last INS beat.
    task automatic run_tail(input string tag);
        #1;
        n_cmp++; if (pe_start !== 1'b0 || fu_bram_sel !== 2'b10) begin n_bad++;
            $display("FAIL %s settle_ins pe_start=%b sel=%b want 0/10", tag, pe_start, fu_bram_sel); end
        cyc(); #1;
        n_cmp++; if (pe_start !== 1'b1 || fu_bram_sel !== 2'b11) begin n_bad++;
            $display("FAIL %s run pe_start=%b sel=%b want 1/11", tag, pe_start, fu_bram_sel); end
        cyc(); #1;
        pe_done = 1'b1; #1;
        n_cmp++; if (pe_start !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL %s wait_pe pe_start=%b busy=%b done=%b want 0/1/0", tag, pe_start, busy, done); end
        cyc(); pe_done = 1'b0; #1;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL %s done done=%b busy=%b want 1/0", tag, done, busy); end
        cyc(); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL %s done_pulse done=%b want 0", tag, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; s_tvalid = 0; s_tlast = 0; pe_done = 0;
        set_cfg(0, 0, 0, 32'h0);
        cyc(); cyc(); rst = 1'b0; #1;
        n_cmp++; if ({s_tready, fu_tvalid, fu_tlast, pe_start, busy, done, err_len, err_cfg} !== 8'h00
                     || fu_bram_sel !== 2'b11 || fu_row_width !== 32'h0) begin n_bad++;
            $display("FAIL reset_vals tready=%b busy=%b done=%b sel=%b rw=%h want 0/0/0/11/0",
                     s_tready, busy, done, fu_bram_sel, fu_row_width); end
        pe_done = 1'b1; cyc(); pe_done = 1'b0; #1;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_pe_done done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_basic();
        logic ftl, ok;
        set_cfg(4, 4, 2, 32'h0000_0040);
        start = 1'b1; #1;
        n_cmp++; if (s_tready !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL basic_idle tready=%b busy=%b want 0/0", s_tready, busy); end
        cyc(); start = 1'b0; #1;
        n_cmp++; if (s_tready !== 1'b1 || fu_bram_sel !== 2'b00 || fu_row_width !== 32'h40) begin n_bad++;
            $display("FAIL basic_in_entry tready=%b sel=%b rw=%h want 1/00/40", s_tready, fu_bram_sel, fu_row_width); end
        beats(4, 4, ftl, ok);
        n_cmp++; if (ok !== 1'b1 || ftl !== 1'b1) begin n_bad++;
            $display("FAIL basic_in_beats ok=%b tlast=%b want 1/1", ok, ftl); end
        #1;
        n_cmp++; if (s_tready !== 1'b0 || fu_bram_sel !== 2'b00) begin n_bad++;
            $display("FAIL basic_settle_in tready=%b sel=%b want 0/00", s_tready, fu_bram_sel); end
        cyc(); #1;
        n_cmp++; if (s_tready !== 1'b1 || fu_bram_sel !== 2'b01) begin n_bad++;
            $display("FAIL basic_ker_entry tready=%b sel=%b want 1/01", s_tready, fu_bram_sel); end
        beats(4, 4, ftl, ok);
        #1;
        n_cmp++; if (ok !== 1'b1 || s_tready !== 1'b0 || fu_bram_sel !== 2'b01) begin n_bad++;
            $display("FAIL basic_settle_ker ok=%b tready=%b sel=%b want 1/0/01", ok, s_tready, fu_bram_sel); end
        cyc(); #1;
        n_cmp++; if (s_tready !== 1'b1 || fu_bram_sel !== 2'b10) begin n_bad++;
            $display("FAIL basic_ins_entry tready=%b sel=%b want 1/10", s_tready, fu_bram_sel); end
        beats(2, 2, ftl, ok);
        n_cmp++; if (ok !== 1'b1 || ftl !== 1'b1) begin n_bad++;
            $display("FAIL basic_ins_beats ok=%b tlast=%b want 1/1", ok, ftl); end
        run_tail("basic");
        n_cmp++; if (err_len !== 1'b0 || err_cfg !== 1'b0) begin n_bad++;
            $display("FAIL basic_errs err_len=%b err_cfg=%b want 0/0", err_len, err_cfg); end
    endtask

    task automatic test_early_tlast();
        logic ftl, ok;
        set_cfg(4, 2, 1, 32'h0000_0010);
        start = 1'b1; cyc(); start = 1'b0;
        beats(3, 3, ftl, ok);
        #1;
        n_cmp++; if (s_tready !== 1'b0 || err_len !== 1'b1 || fu_bram_sel !== 2'b00) begin n_bad++;
            $display("FAIL early_settle tready=%b err_len=%b sel=%b want 0/1/00", s_tready, err_len, fu_bram_sel); end
        cyc(); #1;
        n_cmp++; if (fu_bram_sel !== 2'b01 || s_tready !== 1'b1) begin n_bad++;
            $display("FAIL early_ker sel=%b tready=%b want 01/1", fu_bram_sel, s_tready); end
        beats(2, 2, ftl, ok);
        cyc(); #1;
        n_cmp++; if (fu_bram_sel !== 2'b10) begin n_bad++;
            $display("FAIL early_ins sel=%b want 10", fu_bram_sel); end
        beats(1, 1, ftl, ok);
        run_tail("early");
        n_cmp++; if (err_len !== 1'b1) begin n_bad++;
            $display("FAIL early_sticky err_len=%b want 1", err_len); end
    endtask

    task automatic test_missing_tlast();
        logic ftl, ok;
        set_cfg(2, 0, 1, 32'h0000_0020);
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (err_len !== 1'b0) begin n_bad++;
            $display("FAIL missing_clear err_len=%b want 0", err_len); end
        beats(2, 0, ftl, ok);
        n_cmp++; if (ftl !== 1'b1 || ok !== 1'b1) begin n_bad++;
            $display("FAIL missing_forced_tlast tlast=%b ok=%b want 1/1", ftl, ok); end
        s_tvalid = 1'b1; #1;
        n_cmp++; if (s_tready !== 1'b0 || fu_tvalid !== 1'b0 || err_len !== 1'b1) begin n_bad++;
            $display("FAIL missing_block tready=%b fu_tvalid=%b err_len=%b want 0/0/1", s_tready, fu_tvalid, err_len); end
        s_tvalid = 1'b0;
        cyc(); #1;
        n_cmp++; if (fu_bram_sel !== 2'b10) begin n_bad++;
            $display("FAIL missing_skip_ker sel=%b want 10", fu_bram_sel); end
        beats(1, 1, ftl, ok);
        run_tail("missing");
    endtask

    task automatic test_skip_badcfg();
        logic ftl, ok;
        set_cfg(1, 0, 1, 32'h0000_0008);
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (fu_bram_sel !== 2'b00) begin n_bad++;
            $display("FAIL skip_in sel=%b want 00", fu_bram_sel); end
        beats(1, 1, ftl, ok);
        #1;
        n_cmp++; if (fu_bram_sel !== 2'b00 || s_tready !== 1'b0) begin n_bad++;
            $display("FAIL skip_settle sel=%b tready=%b want 00/0", fu_bram_sel, s_tready); end
        cyc(); #1;
        n_cmp++; if (fu_bram_sel !== 2'b10) begin n_bad++;
            $display("FAIL skip_ins sel=%b want 10", fu_bram_sel); end
        beats(1, 1, ftl, ok);
        run_tail("skip");
        set_cfg(3, 1, 0, 32'h0000_0004);
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0 || err_cfg !== 1'b1 || s_tready !== 1'b0 || fu_bram_sel !== 2'b11) begin n_bad++;
            $display("FAIL badcfg busy=%b err_cfg=%b tready=%b sel=%b want 0/1/0/11", busy, err_cfg, s_tready, fu_bram_sel); end
        cyc(); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL badcfg_idle busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_start_busy_reset();
        logic ftl, ok;
        set_cfg(3, 2, 1, 32'h0000_AAAA);
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (err_cfg !== 1'b0) begin n_bad++;
            $display("FAIL busy_errcfg_clear err_cfg=%b want 0", err_cfg); end
        beats(1, 0, ftl, ok);
        set_cfg(1, 0, 0, 32'h0000_5555);
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (fu_row_width !== 32'hAAAA || err_cfg !== 1'b0 || busy !== 1'b1) begin n_bad++;
            $display("FAIL busy_ignored rw=%h err_cfg=%b busy=%b want aaaa/0/1", fu_row_width, err_cfg, busy); end
        beats(2, 2, ftl, ok);
        #1;
        n_cmp++; if (s_tready !== 1'b0 || err_len !== 1'b0 || ok !== 1'b1) begin n_bad++;
            $display("FAIL busy_len_kept tready=%b err_len=%b ok=%b want 0/0/1", s_tready, err_len, ok); end
        cyc(); #1;
        n_cmp++; if (fu_bram_sel !== 2'b01) begin n_bad++;
            $display("FAIL busy_ker sel=%b want 01", fu_bram_sel); end
        beats(1, 0, ftl, ok);
        rst = 1'b1; s_tvalid = 1'b1;
        cyc(); rst = 1'b0; #1;
        n_cmp++; if ({s_tready, fu_tvalid, fu_tlast, pe_start, busy, done, err_len, err_cfg} !== 8'h00
                     || fu_bram_sel !== 2'b11 || fu_row_width !== 32'h0) begin n_bad++;
            $display("FAIL midker_reset tready=%b fu_tvalid=%b busy=%b sel=%b rw=%h want 0/0/0/11/0",
                     s_tready, fu_tvalid, busy, fu_bram_sel, fu_row_width); end
        s_tvalid = 1'b0;
        cyc();
    endtask

`ifdef LOAD_TIMEOUT_EN
    task automatic test_timeout();
        set_cfg(2, 0, 1, 32'h0000_0002);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i < 8; i++) cyc();
        #1;
        n_cmp++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin n_bad++;
            $display("FAIL timeout_cycle8 busy=%b err_timeout=%b want 1/0", busy, err_timeout); end
        cyc(); #1;
        n_cmp++; if (busy !== 1'b0 || err_timeout !== 1'b1 || fu_bram_sel !== 2'b11 || done !== 1'b0) begin n_bad++;
            $display("FAIL timeout_hit busy=%b err_timeout=%b sel=%b done=%b want 0/1/11/0",
                     busy, err_timeout, fu_bram_sel, done); end
        cyc(); #1;
        n_cmp++; if (done !== 1'b0 || err_timeout !== 1'b1) begin n_bad++;
            $display("FAIL timeout_nodone done=%b err_timeout=%b want 0/1", done, err_timeout); end
        start = 1'b1; cyc(); start = 1'b0; #1;
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++;
            $display("FAIL timeout_clear err_timeout=%b want 0", err_timeout); end
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_early_tlast();
        test_missing_tlast();
        test_skip_badcfg();
        test_start_busy_reset();
`ifdef LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
